// File: rtl/apb_mst_pkg.sv
// rtl/apb_mst_pkg.sv - shared state, size encodings and beat helper for apb_byte_master
package apb_mst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B       = 2'd0;
  localparam logic [1:0] SZ_H       = 2'd1;
  localparam logic [1:0] SZ_W       = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  // Index of the final byte beat for a legal size: (1 << size) - 1.
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      SZ_W:    return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/apb_mst_timeout.sv
// rtl/apb_mst_timeout.sv - ACCESS wait counter with expiry flag, used under APB_MST_TIMEOUT_EN
module apb_mst_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic apb_pclk,
  input  logic apb_prstn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires on the wait cycle whose increment brings the count to TIMEOUT_CYCLES.
  assign expired = count_en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_byte_master.sv
// rtl/apb_byte_master.sv - byte-wide APB initiator for 1/2/4-byte requests; optional APB_MST_TIMEOUT_EN
module apb_byte_master
  import apb_mst_pkg::*;
#(
  parameter int unsigned ADDR_W         = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [7:0]        apb_pwdata,
  input  logic [7:0]        apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [1:0]        beat_q;
  logic [1:0]        beat_nxt;
  logic              timeout_hit;

  logic              psel_d;
  logic              penable_d;
  logic              pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [7:0]        pwdata_d;
  logic              rsp_valid_d;

`ifdef APB_MST_TIMEOUT_EN
  apb_mst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .apb_pclk (apb_pclk),
    .apb_prstn(apb_prstn),
    .clear    (state == ST_SETUP),
    .count_en (state == ST_ACCESS && !apb_pready),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign req_ready = (state == ST_IDLE);
  assign beat_nxt  = beat_q + 2'd1;

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          next_state = (req_size == SZ_ILLEGAL) ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (apb_pready) begin
          if (apb_pslverr || beat_q == last_beat(size_q)) begin
            next_state = ST_RESP;
          end else begin
            next_state = ST_SETUP;
          end
        end else if (timeout_hit) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Bus outputs are computed from the next state so they are flops aligned with the state.
  always_comb begin
    psel_d      = (next_state == ST_SETUP) || (next_state == ST_ACCESS);
    penable_d   = (next_state == ST_ACCESS);
    rsp_valid_d = (next_state == ST_RESP);
    pwrite_d    = apb_pwrite;
    paddr_d     = apb_paddr;
    pwdata_d    = apb_pwdata;
    if (state == ST_IDLE && next_state == ST_SETUP) begin
      pwrite_d = req_write;
      paddr_d  = req_addr;
      pwdata_d = req_wdata[7:0];
    end else if (state == ST_ACCESS && next_state == ST_SETUP) begin
      paddr_d  = addr_q + ADDR_W'(beat_nxt);
      pwdata_d = wdata_q[{beat_nxt, 3'b000} +: 8];
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_paddr   <= '0;
      apb_pwdata  <= '0;
      rsp_valid   <= 1'b0;
    end else begin
      apb_psel    <= psel_d;
      apb_penable <= penable_d;
      apb_pwrite  <= pwrite_d;
      apb_paddr   <= paddr_d;
      apb_pwdata  <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= SZ_B;
      wdata_q   <= '0;
      beat_q    <= 2'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            beat_q  <= 2'd0;
            rsp_err <= (req_size == SZ_ILLEGAL);
          end
        end
        ST_ACCESS: begin
          if (apb_pready) begin
            if (!write_q) begin
              rsp_rdata[{beat_q, 3'b000} +: 8] <= apb_prdata;
            end
            if (apb_pslverr) begin
              rsp_err <= 1'b1;
            end
            if (next_state == ST_SETUP) begin
              beat_q <= beat_nxt;
            end
          end else if (timeout_hit) begin
            rsp_err <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_byte_master.sv
// tb/tb_apb_byte_master.sv - directed bench for apb_byte_master; timeout steps need APB_MST_TIMEOUT_EN
module tb_apb_byte_master;

  logic        apb_pclk = 1'b0;
  logic        apb_prstn;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [19:0] apb_paddr;
  logic [7:0]  apb_pwdata;
  logic [7:0]  apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;

  logic [7:0]  rd_bytes [4];
  logic        slverr_en;
  int          checks = 0;
  int          errors = 0;

  apb_byte_master #(
    .ADDR_W(20),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .apb_pclk   (apb_pclk),
    .apb_prstn  (apb_prstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_paddr  (apb_paddr),
    .apb_pwdata (apb_pwdata),
    .apb_prdata (apb_prdata),
    .apb_pready (apb_pready),
    .apb_pslverr(apb_pslverr)
  );

  always #5 apb_pclk = ~apb_pclk;

  // Slave returns a table byte selected by the low address bits; error only on byte lane 1.
  assign apb_prdata  = rd_bytes[apb_paddr[1:0]];
  assign apb_pslverr = slverr_en && apb_psel && apb_penable && (apb_paddr[1:0] == 2'd1);

  task automatic cyc();
    @(posedge apb_pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [19:0] a, input logic w, input logic [1:0] s, input logic [31:0] d);
    req_addr  = a;
    req_write = w;
    req_size  = s;
    req_wdata = d;
    req_valid = 1'b1;
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    apb_prstn = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_size  = 2'd0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    apb_pready = 1'b1;
    slverr_en = 1'b0;
    for (int i = 0; i < 4; i++) rd_bytes[i] = 8'h00;

    #12;
    chk("rst_psel", {31'd0, apb_psel}, 32'd0);
    chk("rst_penable", {31'd0, apb_penable}, 32'd0);
    chk("rst_pwrite", {31'd0, apb_pwrite}, 32'd0);
    chk("rst_paddr", {12'd0, apb_paddr}, 32'd0);
    chk("rst_pwdata", {24'd0, apb_pwdata}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    apb_prstn = 1'b1;
    cyc();

    // single-byte write
    issue(20'h00010, 1'b1, 2'd0, 32'h000000A5);
    chk("w1_c1_psel", {31'd0, apb_psel}, 32'd1);
    chk("w1_c1_penable", {31'd0, apb_penable}, 32'd0);
    chk("w1_c1_paddr", {12'd0, apb_paddr}, 32'h10);
    chk("w1_c1_pwdata", {24'd0, apb_pwdata}, 32'hA5);
    chk("w1_c1_pwrite", {31'd0, apb_pwrite}, 32'd1);
    chk("w1_c1_req_ready", {31'd0, req_ready}, 32'd0);
    cyc();
    chk("w1_c2_psel", {31'd0, apb_psel}, 32'd1);
    chk("w1_c2_penable", {31'd0, apb_penable}, 32'd1);
    chk("w1_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    cyc();
    chk("w1_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w1_c3_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("w1_c3_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_c3_psel", {31'd0, apb_psel}, 32'd0);
    cyc();
    chk("w1_c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("w1_c4_req_ready", {31'd0, req_ready}, 32'd1);

    // word read, four beats
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    issue(20'h00020, 1'b0, 2'd2, 32'h0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("wr_setup%0d_psel", b), {30'd0, apb_psel, apb_penable}, 32'b10);
      chk($sformatf("wr_setup%0d_paddr", b), {12'd0, apb_paddr}, 32'h20 + b);
      chk($sformatf("wr_setup%0d_pwrite", b), {31'd0, apb_pwrite}, 32'd0);
      cyc();
      chk($sformatf("wr_access%0d_psel", b), {30'd0, apb_psel, apb_penable}, 32'b11);
      cyc();
    end
    chk("wr_c9_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_c9_rsp_rdata", rsp_rdata, 32'h44332211);
    chk("wr_c9_rsp_err", {31'd0, rsp_err}, 32'd0);
    cyc();

    // halfword write with wait states across the address wrap
    issue(20'hFFFFF, 1'b1, 2'd1, 32'h0000BEEF);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("hw_setup%0d_psel", b), {30'd0, apb_psel, apb_penable}, 32'b10);
      chk($sformatf("hw_setup%0d_paddr", b), {12'd0, apb_paddr}, (b == 0) ? 32'hFFFFF : 32'h0);
      chk($sformatf("hw_setup%0d_pwdata", b), {24'd0, apb_pwdata}, (b == 0) ? 32'hEF : 32'hBE);
      cyc();
      apb_pready = 1'b0;
      for (int w = 0; w < 3; w++) begin
        chk($sformatf("hw_wait%0d_%0d_psel", b, w), {30'd0, apb_psel, apb_penable}, 32'b11);
        chk($sformatf("hw_wait%0d_%0d_paddr", b, w), {12'd0, apb_paddr}, (b == 0) ? 32'hFFFFF : 32'h0);
        cyc();
      end
      apb_pready = 1'b1;
      chk($sformatf("hw_ready%0d_penable", b), {31'd0, apb_penable}, 32'd1);
      chk($sformatf("hw_ready%0d_rsp_valid", b), {31'd0, rsp_valid}, 32'd0);
      cyc();
    end
    chk("hw_c11_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("hw_c11_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("hw_c11_rsp_rdata", rsp_rdata, 32'd0);
    cyc();

    // slave error on beat 1 aborts the word read
    rd_bytes[0] = 8'h7E; rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h55; rd_bytes[3] = 8'h66;
    slverr_en = 1'b1;
    issue(20'h00040, 1'b0, 2'd2, 32'h0);
    cyc();
    cyc();
    chk("err_c3_paddr", {12'd0, apb_paddr}, 32'h41);
    chk("err_c3_psel", {30'd0, apb_psel, apb_penable}, 32'b10);
    cyc();
    cyc();
    chk("err_c5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("err_c5_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("err_c5_rsp_rdata", rsp_rdata, 32'h0000007E);
    chk("err_c5_psel", {31'd0, apb_psel}, 32'd0);
    cyc();
    chk("err_c6_psel", {31'd0, apb_psel}, 32'd0);
    chk("err_c6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("err_c6_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("err_c6_rsp_rdata", rsp_rdata, 32'd0);
    slverr_en = 1'b0;

    // illegal size with response backpressure
    rsp_ready = 1'b0;
    issue(20'h00100, 1'b0, 2'd3, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ill_hold%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("ill_hold%0d_rsp_err", k), {31'd0, rsp_err}, 32'd1);
      chk($sformatf("ill_hold%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      chk($sformatf("ill_hold%0d_psel", k), {31'd0, apb_psel}, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    chk("ill_hs_req_ready", {31'd0, req_ready}, 32'd0);
    cyc();
    chk("ill_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ill_after_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("ill_after_req_ready", {31'd0, req_ready}, 32'd1);

`ifdef APB_MST_TIMEOUT_EN
    // pready stuck low: four ACCESS cycles then error response
    apb_pready = 1'b0;
    issue(20'h00005, 1'b0, 2'd0, 32'h0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_access%0d_psel", k), {30'd0, apb_psel, apb_penable}, 32'b11);
      cyc();
    end
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_psel", {30'd0, apb_psel, apb_penable}, 32'b00);
    cyc();
    apb_pready = 1'b1;
`endif

    // asynchronous reset in the middle of ACCESS
    apb_pready = 1'b0;
    issue(20'h00200, 1'b1, 2'd1, 32'h00001234);
    cyc();
    chk("rst_mid_penable_before", {31'd0, apb_penable}, 32'd1);
    #2;
    apb_prstn = 1'b0;
    #1;
    chk("rst_mid_psel", {31'd0, apb_psel}, 32'd0);
    chk("rst_mid_penable", {31'd0, apb_penable}, 32'd0);
    chk("rst_mid_paddr", {12'd0, apb_paddr}, 32'd0);
    chk("rst_mid_pwdata", {24'd0, apb_pwdata}, 32'd0);
    chk("rst_mid_pwrite", {31'd0, apb_pwrite}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    #1;
    apb_pready = 1'b1;
    apb_prstn = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_post%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("rst_post%0d_psel", k), {31'd0, apb_psel}, 32'd0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_byte_master.md
# apb_byte_master

- APB initiator for the 8-bit peripheral bus.
- Accepts one CPU-side request at a time through a valid/ready port: 1-, 2- or 4-byte read or write.
- Issues the request as consecutive little-endian byte-wide APB transfers to the 20-bit peripheral address space, where the interrupt controller, UART, SPI and the other peripherals respond.
- Returns assembled read data and an error flag through a valid/ready response port.

## Interface
Parameters:
- ADDR_W, 20, APB/request address width.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase wait cycles with apb_pready low (used only with timeout feature).

Ports (one clock; reset is asynchronous and active-low):
- apb_pclk  in  1  clock.
- apb_prstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid at the rising edge.
- req_addr  in  ADDR_W  start byte address.
- req_write  in  1  1 = write, 0 = read.
- req_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = illegal.
- req_wdata  in  32  write data; byte k in [8k+7:8k].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; zero for writes.
- rsp_err  out  1  slave error, illegal size or timeout.
- apb_psel, apb_penable, apb_pwrite  out  1  APB controls.
- apb_paddr  out  ADDR_W  APB address.
- apb_pwdata  out  8  APB write data.
- apb_prdata  in  8  APB read data.
- apb_pready  in  1  slave ready; tie high for zero-wait slaves.
- apb_pslverr  in  1  slave error, sampled with apb_pready.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. The state register and all outputs except req_ready are registered.
- **IDLE**
  - req_ready = 1 (req_ready = state==IDLE).
  - On the handshake, capture addr, write, size and wdata, and set beat = 0.
  - size 3 → RESP with rsp_err = 1; no bus transfer.
  - Otherwise → SETUP.
- **SETUP**
  - psel = 1, penable = 0.
  - paddr = addr + beat, truncated to ADDR_W (wraps 0xFFFFF → 0x00000).
  - pwdata = wdata[8·beat+7:8·beat]; pwrite = captured write.
  - Always → ACCESS next cycle.
- **ACCESS**
  - psel = 1, penable = 1; address, data and direction held stable.
  - Stays in ACCESS while pready = 0.
  - When pready = 1:
    - Read: prdata is stored in rdata byte `beat`.
    - If pslverr = 1 → RESP with err = 1. Remaining beats are not issued; bytes not read stay 0.
    - Else if beat = (1<<size)−1 → RESP.
    - Else beat+1 → SETUP. psel stays high between beats; penable drops.
- **RESP**
  - psel = penable = 0; rsp_valid = 1.
  - rsp_rdata and rsp_err are held until rsp_ready.
  - On the handshake → IDLE, with rdata/err cleared.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Reset values: psel, penable, pwrite = 0; paddr, pwdata = 0; rsp_valid, rsp_err = 0; rsp_rdata = 0; state IDLE, so req_ready = 1.
- Reset mid-transfer: all outputs go to their reset values immediately. The transaction is dropped and no response is produced.

## Timing
- The request handshake is at edge 0.
- With pready tied high:
  - SETUP in cycle 1, ACCESS in cycle 2, rsp_valid high from cycle 3.
  - N beats: rsp_valid from cycle 2N+1.
- Each pready=0 cycle in ACCESS adds one cycle.
- Illegal size: rsp_valid high from cycle 1.
- Response latency is independent of rsp_ready; rsp_valid stays high until the handshake.

## Configuration
- APB_MST_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM → RESP with err = 1 and drops psel/penable.
  - Bytes already read are returned.
- APB_MST_TIMEOUT_EN undefined:
  - The FSM waits indefinitely for pready.
  - TIMEOUT_CYCLES is unused and no counter logic exists.

## Structure
- Shared package apb_mst_pkg holds:
  - the state encoding;
  - the size encodings (SZ_B = 0, SZ_H = 1, SZ_W = 2);
  - the beat-count function.
- One sub-module, apb_mst_timeout: the wait counter plus expiry flag, instantiated only under APB_MST_TIMEOUT_EN.

## Test plan
- **Single-byte write:** write size 0, addr 0x00010, wdata 0x000000A5, pready = 1 → one transfer: paddr 0x00010, pwdata 0xA5, pwrite = 1, psel/penable pattern 10→11; rsp_valid in cycle 3; rsp_err = 0.
- **Word read:** read size 2, addr 0x00020, slave returns 0x11, 0x22, 0x33, 0x44 → paddr 0x20–0x23; rsp_rdata = 0x44332211 at cycle 9.
- **Wait states and wrap:** halfword write at addr 0xFFFFF with pready low 3 cycles per beat → paddr 0xFFFFF then 0x00000; penable held through waits; rsp_valid at cycle 11.
- **Error abort:** word read with pslverr = 1 on beat 1 (prdata 0x7E on beat 0) → beats 2–3 not issued; rsp_rdata = 0x0000007E; rsp_err = 1.
- **Illegal size and response backpressure:** size 3 → no psel; rsp_err = 1 at cycle 1. Hold rsp_ready low 5 cycles → response stable, req_ready = 0 until the handshake.
- **Timeout:** with APB_MST_TIMEOUT_EN and TIMEOUT_CYCLES = 4, pready stuck low → rsp_err = 1 after 4 ACCESS cycles. Separately, assert apb_prstn low mid-ACCESS → psel = 0 immediately and no response.
